// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle IEEE-754 single-precision to signed int32 converter.
//   Sequence: IDLE -> CHECK (classify) -> ALIGN (barrel shift) -> ROUND -> DONE.
//   Fixed 4-cycle latency from accept to done_tick for every input class.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   en              start request, sampled only in IDLE
//   a, rmode        operand and rounding mode (0 = nearest-even, 1 = truncate), captured on accept
//   busy            high whenever the FSM is not in IDLE
//   done_tick       one-cycle pulse while in DONE
//   o, NaN, inf     registered result and flags, held until the next DONE
//   inexact         only with macro FP2INT_INEXACT_EN: discarded fraction bits were nonzero
module fp_to_int (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] a,
  input  logic        rmode,
  output logic        busy,
  output logic        done_tick,
  output logic [31:0] o,
  output logic        NaN,
  output logic        inf
`ifdef FP2INT_INEXACT_EN
  , output logic      inexact
`endif
);

  localparam int unsigned MAN_W = 24;
  localparam int unsigned EXP_W = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;  // infinity or out of int32 range
  localparam logic [1:0] CLS_NAN  = 2'd3;

  localparam logic [EXP_W-1:0] EXP_INT = EXP_W'(150);  // exponent where m is already an integer
  localparam logic [EXP_W-1:0] EXP_OVF = EXP_W'(158);  // exponent of 2^31
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(255);

  logic [2:0]       state, state_n;
  logic [31:0]      a_q;
  logic             rmode_q;
  logic [1:0]       cls_q;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] man_q;
  logic [31:0]      mag_q;
  logic             guard_q;
  logic             sticky_q;

  // Operand fields of the latched word
  logic [EXP_W-1:0] a_exp;
  logic [22:0]      a_frac;
  assign a_exp  = a_q[30:23];
  assign a_frac = a_q[22:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en) state_n = CHECK;
      CHECK:   state_n = ALIGN;
      ALIGN:   state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand classification
  logic [1:0] cls_c;
  always_comb begin
    cls_c = CLS_NORM;
    if (a_exp == EXP_MAX)
      cls_c = (a_frac != 23'd0) ? CLS_NAN : CLS_INF;
    else if (a_exp == EXP_W'(0))
      cls_c = CLS_ZERO;
    else if (a_exp > EXP_OVF)
      cls_c = CLS_INF;
    else if (a_exp == EXP_OVF && !(a_frac == 23'd0 && a_q[31]))
      cls_c = CLS_INF;  // only exact -2^31 survives at this exponent
  end

  // Alignment shifter: integer magnitude plus guard/sticky of the dropped bits
  logic [EXP_W-1:0] k_c;
  logic [4:0]       k5_c;
  logic [31:0]      mag_c;
  logic             guard_c;
  logic             sticky_c;
  always_comb begin
    k_c      = EXP_INT - exp_q;
    k5_c     = k_c[4:0];
    mag_c    = 32'd0;
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    if (exp_q >= EXP_INT) begin
      mag_c = 32'(man_q) << (exp_q - EXP_INT);
    end else if (k_c >= EXP_W'(25)) begin
      sticky_c = |man_q;
    end else begin
      mag_c    = 32'(man_q >> k5_c);
      guard_c  = man_q[k5_c - 5'd1];
      sticky_c = |(man_q & ((MAN_W'(1) << (k5_c - 5'd1)) - MAN_W'(1)));
    end
  end

  // Rounding and sign application
  logic        inc_c;
  logic [31:0] mag_rnd_c;
  logic [31:0] res_c;
  always_comb begin
    inc_c     = !rmode_q && guard_q && (sticky_q || mag_q[0]);
    mag_rnd_c = mag_q + 32'(inc_c);
    res_c     = sign_q ? (32'd0 - mag_rnd_c) : mag_rnd_c;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= 32'd0;
      rmode_q   <= 1'b0;
      cls_q     <= CLS_NORM;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      man_q     <= '0;
      mag_q     <= 32'd0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      busy      <= 1'b0;
      done_tick <= 1'b0;
      o         <= 32'd0;
      NaN       <= 1'b0;
      inf       <= 1'b0;
`ifdef FP2INT_INEXACT_EN
      inexact   <= 1'b0;
`endif
    end else begin
      busy      <= (state_n != IDLE);
      done_tick <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (en) begin
            a_q     <= a;
            rmode_q <= rmode;
          end
        end
        CHECK: begin
          cls_q  <= cls_c;
          sign_q <= a_q[31];
          exp_q  <= a_exp;
          // hidden bit is 0 for zero/denormal so sticky reflects only the fraction
          man_q  <= {a_exp != EXP_W'(0), a_frac};
        end
        ALIGN: begin
          mag_q    <= mag_c;
          guard_q  <= guard_c;
          sticky_q <= sticky_c;
        end
        ROUND: begin
          NaN <= 1'b0;
          inf <= 1'b0;
`ifdef FP2INT_INEXACT_EN
          inexact <= 1'b0;
`endif
          case (cls_q)
            CLS_NAN: begin
              o   <= 32'h8000_0000;
              NaN <= 1'b1;
            end
            CLS_INF: begin
              o   <= sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
              inf <= 1'b1;
            end
            CLS_ZERO: begin
              o <= 32'd0;
`ifdef FP2INT_INEXACT_EN
              inexact <= guard_q | sticky_q;
`endif
            end
            default: begin
              o <= res_c;
`ifdef FP2INT_INEXACT_EN
              inexact <= guard_q | sticky_q;
`endif
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: self-checking bench for fp_to_int (directed table, random vs real-valued model,
// back-to-back accepts with en held high, reset abort mid-conversion).
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] a;
  logic        rmode;
  logic        busy;
  logic        done_tick;
  logic [31:0] o;
  logic        NaN;
  logic        inf;
`ifdef FP2INT_INEXACT_EN
  logic        inexact;
`endif

  int n_vec = 0;
  int n_err = 0;

  fp_to_int dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .a         (a),
    .rmode     (rmode),
    .busy      (busy),
    .done_tick (done_tick),
    .o         (o),
    .NaN       (NaN),
    .inf       (inf)
`ifdef FP2INT_INEXACT_EN
    , .inexact (inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] o;
    logic        nan;
    logic        inf;
    logic        inx;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic        rm;
    res_t        exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: evaluate the float as a real number, then round/saturate arithmetically
  function automatic res_t model(input logic [31:0] av, input logic rm);
    res_t   r;
    int     e;
    logic   neg;
    real    v, tr, fr, q;
    longint li;
    r   = '0;
    neg = av[31];
    e   = int'(av[30:23]);
    if (e == 255) begin
      if (av[22:0] != 23'd0) begin
        r.o = 32'h8000_0000; r.nan = 1'b1;
      end else begin
        r.o = neg ? 32'h8000_0000 : 32'h7FFF_FFFF; r.inf = 1'b1;
      end
      return r;
    end
    if (e == 0) v = real'(av[22:0]) * (2.0 ** (-149.0));
    else        v = real'({1'b1, av[22:0]}) * (2.0 ** (real'(e) - 150.0));
    if (v > 2147483648.0 || (v == 2147483648.0 && !neg)) begin
      r.o = neg ? 32'h8000_0000 : 32'h7FFF_FFFF; r.inf = 1'b1;
      return r;
    end
    tr = $floor(v);
    fr = v - tr;
    if (rm)             q = tr;
    else if (fr > 0.5)  q = tr + 1.0;
    else if (fr < 0.5)  q = tr;
    else                q = ($floor(tr / 2.0) * 2.0 == tr) ? tr : tr + 1.0;
    li    = longint'(q);
    r.o   = 32'(neg ? -li : li);
    r.inx = (fr != 0.0);
    return r;
  endfunction

  task automatic chk_result(input string tag, input res_t ex);
    chk({tag, ".o"},   o,           ex.o);
    chk({tag, ".NaN"}, 32'(NaN),    32'(ex.nan));
    chk({tag, ".inf"}, 32'(inf),    32'(ex.inf));
`ifdef FP2INT_INEXACT_EN
    chk({tag, ".inexact"}, 32'(inexact), 32'(ex.inx));
`endif
  endtask

  // One conversion starting at a negedge; checks done_tick/busy timing and the result
  task automatic run(input string tag, input logic [31:0] av, input logic rm, input res_t ex);
    en = 1'b1; a = av; rmode = rm;
    @(posedge clk);                        // edge T
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        en = 1'b0; a = $urandom; rmode = $urandom_range(0, 1);
      end
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done"}, 32'(done_tick), (i == 4) ? 32'd1 : 32'd0);
    end
    chk_result(tag, ex);
    @(negedge clk);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".done_end"}, 32'(done_tick), 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    res_t        ex;
    logic [31:0] av, ops[3];
    logic        rm;

    // {a, rmode, {o, NaN, inf, inexact}}
    tbl.push_back('{32'h40490FDB, 1'b0, '{32'h0000_0003, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'h40200000, 1'b0, '{32'h0000_0002, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'h40600000, 1'b0, '{32'h0000_0004, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'hC0200000, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'h3FF00000, 1'b1, '{32'h0000_0001, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'h3FF00000, 1'b0, '{32'h0000_0002, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'h4F000000, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}});
    tbl.push_back('{32'hCF000000, 1'b0, '{32'h8000_0000, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{32'hCF000001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}});
    tbl.push_back('{32'h4EFFFFFF, 1'b0, '{32'h7FFF_FF80, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{32'h7FC00000, 1'b0, '{32'h8000_0000, 1'b1, 1'b0, 1'b0}});
    tbl.push_back('{32'hFF800000, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}});
    tbl.push_back('{32'h7F800000, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}});
    tbl.push_back('{32'h80000000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{32'h00000001, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'h3F000000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'h3F000001, 1'b0, '{32'h0000_0001, 1'b0, 1'b0, 1'b1}});
    tbl.push_back('{32'hBF800000, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}});

    reset = 1'b1; en = 1'b0; a = 32'h0; rmode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.o", o, 32'd0);
    chk("rst.flags", {30'd0, NaN, inf}, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done_tick), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i].a, tbl[i].rm, tbl[i].exp);

    // Random operands against the real-valued model
    for (int n = 0; n < 300; n++) begin
      logic [7:0] e;
      logic [22:0] f;
      case ($urandom_range(0, 9))
        0:       e = 8'd255;
        1:       e = 8'd0;
        2:       e = 8'd158;
        default: e = 8'($urandom_range(100, 165));
      endcase
      f  = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
      av = {1'($urandom), e, f};
      rm = 1'($urandom);
      run($sformatf("rnd%0d_%h_%0d", n, av, rm), av, rm, model(av, rm));
    end

    // en held high: accepts every 5 cycles, operand churn between accepts ignored
    for (int i = 0; i < 3; i++) ops[i] = {1'b0, 8'($urandom_range(127, 156)), 23'($urandom)};
    en = 1'b1; a = ops[0]; rmode = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      a = ((c % 5) == 0 && c < 15) ? ops[c / 5] : $urandom;
      chk($sformatf("hold.done%0d", c), 32'(done_tick), ((c % 5) == 4) ? 32'd1 : 32'd0);
      chk($sformatf("hold.busy%0d", c), 32'(busy), ((c % 5) == 0) ? 32'd0 : 32'd1);
      if ((c % 5) == 4) chk_result($sformatf("hold%0d", c / 5), model(ops[c / 5], 1'b0));
    end
    en = 1'b0;
    @(negedge clk);

    // Reset pulsed while in ALIGN aborts the conversion
    ex = model(32'h42F60000, 1'b0);
    en = 1'b1; a = 32'hC2F60000; rmode = 1'b0;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    @(negedge clk);                          // state ALIGN
    reset = 1'b1;
    #1;
    chk("abort.o", o, 32'd0);
    chk("abort.flags", {30'd0, NaN, inf}, 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("abort.nodone%0d", c), 32'(done_tick), 32'd0);
    end
    chk("abort.model", ex.o, 32'd123);
    run("after_abort", 32'h42F60000, 1'b0, ex);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
